// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads to the instruction bus, holds the
// fetched word across pipeline stalls, tracks branch redirects and halts on a jump to 0.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instruction_fetch,
    output logic        fetch_valid,
    output logic [31:0] program_counter_plus_four_fetch,
    output logic        HALT_fetch,
    output logic        bus_stall_request
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   hold_buffer_q, hold_buffer_d;
    logic [XLEN-1:0]   redirect_target_q, redirect_target_d;
    logic              redirect_pending_q, redirect_pending_d;

    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   target_aligned;
    logic [XLEN-1:0]   load_addr;
    logic              load_pc;
    logic              accept;

    assign pc_plus4       = pc_q + XLEN'(4);
    assign target_aligned = branch_target & ~XLEN'(3);

    // The bus is only driven while out of reset so an in-flight read is dropped at once.
    assign instr_read = reset && (state_q == S_FETCH);
    assign accept     = instr_read && !instr_waitrequest;

    // Next-state: decide whether the pc is reloaded and from where.
    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        hold_buffer_d      = hold_buffer_q;
        redirect_target_d  = redirect_target_q;
        redirect_pending_d = redirect_pending_q;
        load_pc            = 1'b0;
        load_addr          = pc_plus4;

        case (state_q)
            S_FETCH: begin
                if (instr_waitrequest) begin
                    if (branch_taken && !stall) begin
                        redirect_pending_d = 1'b1;
                        redirect_target_d  = target_aligned;
                    end
                end else if (redirect_pending_q) begin
                    load_pc            = 1'b1;
                    load_addr          = redirect_target_q;
                    redirect_pending_d = 1'b0;
                end else if (stall) begin
                    hold_buffer_d = instr_readdata;
                    state_d       = S_HOLD;
                end else begin
                    load_pc   = 1'b1;
                    load_addr = branch_taken ? target_aligned : pc_plus4;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    load_pc   = 1'b1;
                    load_addr = branch_taken ? target_aligned : pc_plus4;
                end
            end
            default: ;
        endcase

        // Address 0 is the halt marker and is never fetched.
        if (load_pc) begin
            pc_d    = load_addr;
            state_d = (load_addr == '0) ? S_HALTED : S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= S_FETCH;
            pc_q               <= RESET_VECTOR;
            hold_buffer_q      <= '0;
            redirect_target_q  <= '0;
            redirect_pending_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            pc_q               <= pc_d;
            hold_buffer_q      <= hold_buffer_d;
            redirect_target_q  <= redirect_target_d;
            redirect_pending_q <= redirect_pending_d;
        end
    end

    // Accepted data goes straight to decode unless it belongs to a squashed path.
    assign fetch_valid       = (accept && !redirect_pending_q) || (state_q == S_HOLD);
    assign instruction_fetch = (state_q == S_HOLD) ? hold_buffer_q : instr_readdata;
    assign instr_address     = pc_q;
    assign program_counter_plus_four_fetch = pc_plus4;
    assign HALT_fetch        = (state_q == S_HALTED);
    assign bus_stall_request = instr_read && instr_waitrequest;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_VECTOR, default 32'hBFC00000, first instruction address after reset.
REQ-002 The module SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 The module SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 The module SHALL have port stall  input  1  hazard-unit stall, active high; same signal that holds the fetch/decode register.
REQ-005 The module SHALL have port branch_taken  input  1  redirect request from decode.
REQ-006 The module SHALL have port branch_target  input  32  redirect address; bits[1:0] ignored.
REQ-007 The module SHALL have port instr_address  output  32  memory bus word address.
REQ-008 The module SHALL have port instr_read  output  1  bus read strobe.
REQ-009 The module SHALL have port instr_waitrequest  input  1  bus not ready; request held while high.
REQ-010 The module SHALL have port instr_readdata  input  32  bus read data, valid when instr_read=1 and instr_waitrequest=0.
REQ-011 The module SHALL have port instruction_fetch  output  32  fetched instruction.
REQ-012 The module SHALL have port fetch_valid  output  1  instruction_fetch and program_counter_plus_four_fetch valid this cycle.
REQ-013 The module SHALL have port program_counter_plus_four_fetch  output  32  PC+4 of the presented instruction.
REQ-014 The module SHALL have port HALT_fetch  output  1  sticky halt indication to the fetch/decode register.
REQ-015 The module SHALL have port bus_stall_request  output  1  high while a read is waiting (FETCH and instr_waitrequest=1).

Function
REQ-016 The module SHALL implement states FETCH, HOLD, HALTED; registers pc[31:0], hold_buffer[31:0], redirect_pending, redirect_target[31:0].
REQ-017 FETCH: instr_read=1, instr_address=pc; address held stable while instr_waitrequest=1.
REQ-018 Accept = FETCH and instr_waitrequest=0; on accept with redirect_pending=0, fetch_valid=1 combinationally, instruction_fetch=instr_readdata (zero-latency).
REQ-019 Accept with stall=0: pc<=pc+4 (or branch target, REQ-022); stay FETCH.
REQ-020 Accept with stall=1: hold_buffer<=instr_readdata; enter HOLD; pc unchanged.
REQ-021 HOLD: instr_read=0, fetch_valid=1, instruction_fetch=hold_buffer; stall=0 -> pc advance as REQ-019, return to FETCH.
REQ-022 branch_taken=1 with stall=0 and no read outstanding (HOLD, or FETCH accept): pc<={branch_target[31:2],2'b00}; overrides pc+4.
REQ-023 branch_taken=1 while FETCH with instr_waitrequest=1: redirect_pending<=1, redirect_target<=aligned target; bus request not altered.
REQ-024 Accept with redirect_pending=1: data discarded, fetch_valid=0, pc<=redirect_target, redirect_pending<=0, regardless of stall.
REQ-025 branch_taken while stall=1 SHALL be ignored (decode re-presents it).
REQ-026 program_counter_plus_four_fetch = pc+4 modulo 2^32 (pc 32'hFFFFFFFC -> 32'h00000000).
REQ-027 Any update loading pc with 32'h00000000 SHALL instead enter HALTED, pc<=0; no read is ever issued to address 0.
REQ-028 HALTED: instr_read=0, fetch_valid=0, HALT_fetch=1, all inputs ignored until reset.
REQ-029 HALT_fetch SHALL be 0 in FETCH and HOLD.
REQ-030 bus_stall_request SHALL be 0 in HOLD and HALTED.

Reset
REQ-031 reset=0 SHALL immediately (asynchronously) force state=FETCH, pc=RESET_VECTOR, redirect_pending=0, hold_buffer=0, HALT_fetch=0, fetch_valid=0.
REQ-032 During reset instr_read SHALL be 0; the first read (address RESET_VECTOR) is issued in the first cycle after reset=1.
REQ-033 Reset asserted mid-read SHALL abandon the read; returned data is never presented.

Verification
REQ-034 Zero-wait bus, stall=0: reads at BFC00000, BFC00004, BFC00008 in consecutive cycles; PC+4 outputs BFC00004, BFC00008, BFC0000C.
REQ-035 waitrequest high 3 cycles at BFC00000: address stable, bus_stall_request=1 three cycles, fetch_valid=0 until accept.
REQ-036 stall=1 at accept of 0x24020005: HOLD, instr_read=0, instruction_fetch held 0x24020005 until stall=0, then read BFC00004.
REQ-037 branch_taken with target 0xBFC00103 during waitrequest=1: pending read completes, data dropped (fetch_valid=0), next read at 0xBFC00100.
REQ-038 branch_taken target 0x00000000: HALTED next cycle, HALT_fetch=1, no further reads; reset=0 then 1 restarts at BFC00000.
